// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep checker: mismatch counter width, its
// saturation limit and the saturating increment used by the top level.
package lockstep_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] err_cnt_t;

    localparam err_cnt_t ERR_CNT_MAX = '1;

    function automatic err_cnt_t sat_inc(input err_cnt_t value);
        return (value == ERR_CNT_MAX) ? value : value + err_cnt_t'(1);
    endfunction

endpackage

// File: rtl/skew_fifo.sv
// Per-side realignment FIFO for the lockstep checker. It never stalls the
// producer: a push into a full FIFO is dropped unless a pop frees a slot this cycle.
module skew_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             accept;

    assign full   = (count == FULL_CNT);
    assign accept = push && (!full || pop);
    assign drop   = push && !accept;
    assign dout   = mem[rd_ptr];

    // NOTE: storage has no reset; the count gates every read, so stale
    // contents are never compared and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lockstep_checker.sv
// Runtime lockstep comparator: realigns reference and UUT streams and compares
// them in order. Define LOCKSTEP_FIRST_ERR_CAPTURE_EN to capture the first mismatching pair.
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             ref_valid,
    input  logic [WIDTH-1:0] ref_data,
    input  logic             uut_valid,
    input  logic [WIDTH-1:0] uut_data,
    output logic             match_valid,
    output logic             mismatch,
    output logic             error,
    output logic             overflow,
    output err_cnt_t         err_count,
    output logic [WIDTH-1:0] first_ref,
    output logic [WIDTH-1:0] first_uut
);

    logic [WIDTH-1:0]       ref_head;
    logic [WIDTH-1:0]       uut_head;
    logic [$clog2(DEPTH):0] ref_count;
    logic [$clog2(DEPTH):0] uut_count;
    logic                   ref_full;
    logic                   uut_full;
    logic                   ref_drop;
    logic                   uut_drop;
    logic                   pop;
    logic                   pop_neq;

    // Occupancy alone decides pops and drops; the full flags are informational here.
    logic unused_full;
    assign unused_full = ref_full ^ uut_full;

    assign pop     = (ref_count != '0) && (uut_count != '0);
    assign pop_neq = pop && (ref_head != uut_head);

    skew_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ref_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ref_valid),
        .din   (ref_data),
        .pop   (pop),
        .dout  (ref_head),
        .count (ref_count),
        .full  (ref_full),
        .drop  (ref_drop)
    );

    skew_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_uut_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uut_valid),
        .din   (uut_data),
        .pop   (pop),
        .dout  (uut_head),
        .count (uut_count),
        .full  (uut_full),
        .drop  (uut_drop)
    );

    // Clear only affects the sticky state; the compare result itself is still presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_valid <= 1'b0;
            mismatch    <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
            err_count   <= '0;
        end else begin
            match_valid <= pop;
            mismatch    <= pop_neq;
            if (clear) begin
                error     <= 1'b0;
                overflow  <= 1'b0;
                err_count <= '0;
            end else begin
                if (pop_neq) begin
                    error     <= 1'b1;
                    err_count <= sat_inc(err_count);
                end
                if (ref_drop || uut_drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef LOCKSTEP_FIRST_ERR_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_ref <= '0;
            first_uut <= '0;
        end else if (clear) begin
            first_ref <= '0;
            first_uut <= '0;
        end else if (pop_neq && !error) begin
            first_ref <= ref_head;
            first_uut <= uut_head;
        end
    end
`else
    assign first_ref = '0;
    assign first_uut = '0;
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Self-checking bench for lockstep_checker: directed scenarios plus a random
// phase, all scored against a queue-based model of the pairing rules.
module tb_lockstep_checker;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             ref_valid;
    logic [WIDTH-1:0] ref_data;
    logic             uut_valid;
    logic [WIDTH-1:0] uut_data;
    logic             match_valid;
    logic             mismatch;
    logic             error;
    logic             overflow;
    logic [15:0]      err_count;
    logic [WIDTH-1:0] first_ref;
    logic [WIDTH-1:0] first_uut;

    lockstep_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .ref_valid   (ref_valid),
        .ref_data    (ref_data),
        .uut_valid   (uut_valid),
        .uut_data    (uut_data),
        .match_valid (match_valid),
        .mismatch    (mismatch),
        .error       (error),
        .overflow    (overflow),
        .err_count   (err_count),
        .first_ref   (first_ref),
        .first_uut   (first_uut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sample queues per side plus expected output values.
    logic [WIDTH-1:0] ref_q[$];
    logic [WIDTH-1:0] uut_q[$];
    bit               m_mv;
    bit               m_mm;
    bit               m_err;
    bit               m_ovf;
    int               m_cnt;
    logic [WIDTH-1:0] m_fr;
    logic [WIDTH-1:0] m_fu;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".match_valid"}, 32'(match_valid), 32'(m_mv));
        check({tag, ".mismatch"},    32'(mismatch),    32'(m_mm));
        check({tag, ".error"},       32'(error),       32'(m_err));
        check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
        check({tag, ".err_count"},   32'(err_count),   32'(m_cnt));
        check({tag, ".first_ref"},   32'(first_ref),   32'(m_fr));
        check({tag, ".first_uut"},   32'(first_uut),   32'(m_fu));
    endtask

    task automatic model_reset();
        ref_q.delete();
        uut_q.delete();
        m_mv  = 0;
        m_mm  = 0;
        m_err = 0;
        m_ovf = 0;
        m_cnt = 0;
        m_fr  = '0;
        m_fu  = '0;
    endtask

    // One clock edge of the pairing rules, using the inputs present before the edge.
    task automatic model_edge(input bit rv, input logic [WIDTH-1:0] rd,
                              input bit uv, input logic [WIDTH-1:0] ud, input bit clr);
        bit do_pop;
        bit neq;
        bit r_drop;
        bit u_drop;
        do_pop = (ref_q.size() > 0) && (uut_q.size() > 0);
        neq    = do_pop && (ref_q[0] != uut_q[0]);
        r_drop = rv && (ref_q.size() >= DEPTH) && !do_pop;
        u_drop = uv && (uut_q.size() >= DEPTH) && !do_pop;
`ifdef LOCKSTEP_FIRST_ERR_CAPTURE_EN
        if (clr) begin
            m_fr = '0;
            m_fu = '0;
        end else if (neq && !m_err) begin
            m_fr = ref_q[0];
            m_fu = uut_q[0];
        end
`endif
        if (do_pop) begin
            void'(ref_q.pop_front());
            void'(uut_q.pop_front());
        end
        if (rv && !r_drop) ref_q.push_back(rd);
        if (uv && !u_drop) uut_q.push_back(ud);
        m_mv = do_pop;
        m_mm = neq;
        if (clr) begin
            m_err = 0;
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            if (neq) begin
                m_err = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (r_drop || u_drop) m_ovf = 1;
        end
    endtask

    task automatic step(input string tag, input bit rv, input logic [WIDTH-1:0] rd,
                        input bit uv, input logic [WIDTH-1:0] ud, input bit clr = 1'b0);
        ref_valid = rv;
        ref_data  = rd;
        uut_valid = uv;
        uut_data  = ud;
        clear     = clr;
        @(posedge clk);
        model_edge(rv, rd, uv, ud, clr);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic logic [WIDTH-1:0] stim(input int idx);
        return WIDTH'((idx * 37 + 5) & 8'hFF);
    endfunction

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        ref_valid = 1'b0;
        ref_data  = '0;
        uut_valid = 1'b0;
        uut_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Aligned streams: results appear two edges after each write.
        step("aligned0", 1'b1, 8'h11, 1'b1, 8'h11);
        check("aligned.latency_n1", 32'(match_valid), 32'd0);
        step("aligned1", 1'b1, 8'h22, 1'b1, 8'h22);
        check("aligned.latency_n2", 32'(match_valid), 32'd1);
        step("aligned2", 1'b1, 8'h33, 1'b1, 8'h33);
        idle("aligned_tail", 3);
        check("aligned.err_count", 32'(err_count), 32'd0);

        // UUT three cycles behind the reference with identical data.
        for (int i = 0; i < 7; i++) begin
            step("skew3", i < 4, stim(40 + i), (i >= 3), stim(40 + i - 3));
        end
        idle("skew3_tail", 3);
        check("skew3.overflow", 32'(overflow), 32'd0);
        check("skew3.error", 32'(error), 32'd0);

        // Mismatch on the second pair, then a later one that must not re-capture.
        step("mm0", 1'b1, 8'h10, 1'b1, 8'h10);
        step("mm1", 1'b1, 8'hA5, 1'b1, 8'hA4);
        step("mm2", 1'b1, 8'h00, 1'b1, 8'hFF);
        check("mm.result_pair2", 32'(mismatch), 32'd1);
        check("mm.err_count_1", 32'(err_count), 32'd1);
        idle("mm_tail", 3);
        check("mm.err_count_2", 32'(err_count), 32'd2);
`ifdef LOCKSTEP_FIRST_ERR_CAPTURE_EN
        check("mm.first_ref", 32'(first_ref), 32'hA5);
        check("mm.first_uut", 32'(first_uut), 32'hA4);
`else
        check("mm.first_ref_off", 32'(first_ref), 32'h0);
`endif

        // Asynchronous reset with two reference samples still buffered.
        step("prerst0", 1'b1, 8'h55, 1'b0, '0);
        step("prerst1", 1'b1, 8'h66, 1'b0, '0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        check("async_rst.error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("postrst0", 1'b1, 8'h77, 1'b1, 8'h77);
        step("postrst1", 1'b1, 8'h88, 1'b1, 8'h88);
        idle("postrst_tail", 3);
        check("postrst.error", 32'(error), 32'd0);

        // Reference sends DEPTH+1 samples while the UUT is idle.
        for (int i = 0; i < 5; i++) step("ovf_fill", 1'b1, stim(60 + i), 1'b0, '0);
        check("ovf.count_ref", 32'(u_dut.u_ref_fifo.count), 32'd4);
        check("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) step("ovf_drain", 1'b0, '0, 1'b1, stim(60 + i));
        idle("ovf_tail", 3);
        check("ovf.no_mismatch", 32'(error), 32'd0);
        step("ovf_clear", 1'b0, '0, 1'b0, '0, 1'b1);
        check("ovf.cleared", 32'(overflow), 32'd0);

        // Random valids, occasional corruption and clears.
        begin
            int ri = 0;
            int ui = 0;
            for (int c = 0; c < 2000; c++) begin
                bit               rv;
                bit               uv;
                logic [WIDTH-1:0] ud;
                rv = ($urandom % 4) != 0;
                uv = ($urandom % 4) != 0;
                ud = stim(ui);
                if ($urandom_range(0, 15) == 0) ud = ud ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                step("random", rv, stim(ri), uv, ud, ($urandom_range(0, 63) == 0));
                if (rv) ri++;
                if (uv) ui++;
            end
        end

        // Saturation: clean restart, then continuous mismatches.
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        while (m_cnt < 65535) step("sat_fill", 1'b1, 8'h00, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step("sat_hold", 1'b1, 8'h00, 1'b1, 8'hFF);
        check("sat.err_count", 32'(err_count), 32'hFFFF);
        step("sat_clear", 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1);
        check("sat_clear.mismatch", 32'(mismatch), 32'd1);
        check("sat_clear.error", 32'(error), 32'd0);
        check("sat_clear.err_count", 32'(err_count), 32'd0);
        idle("sat_tail", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Runtime counterpart of the team's formal equivalence miter. It consumes the output streams of a reference instance and a unit-under-test instance that share identical inputs but may differ in latency. It realigns the two streams in small per-side FIFOs, compares them sample by sample in order, and reports per-sample match results, a sticky error flag and a saturating mismatch counter. It sits beside duplicated (lockstep) datapath blocks in simulation, emulation or silicon.

## Interface
Parameters:
- WIDTH, 8: data width of each compared stream.
- DEPTH, 4: entries per side FIFO. Must be a power of 2 and at least 2. This bounds the tolerated latency skew.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous clear of the sticky flags, the counter and the capture registers. Does not flush the FIFOs.
- ref_valid  in  1  reference sample present this cycle.
- ref_data  in  WIDTH  reference sample.
- uut_valid  in  1  UUT sample present this cycle.
- uut_data  in  WIDTH  UUT sample.
- match_valid  out  1  one compare result is presented this cycle.
- mismatch  out  1  qualified by match_valid; 1 means the compared pair differed.
- error  out  1  sticky; set by any mismatch.
- overflow  out  1  sticky; set when a sample is dropped into a full FIFO.
- err_count  out  16  saturating count of mismatches.
- first_ref  out  WIDTH  reference data of the first mismatching pair.
- first_uut  out  WIDTH  UUT data of the first mismatching pair.

## Operation
- No backpressure exists; inputs are accepted every cycle they are valid.
- Each side has a FIFO with write pointer, read pointer and count. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- push_x = x_valid. A push is accepted if count_x < DEPTH, or if a pop of that side occurs in the same cycle.
- A push into a full FIFO with no same-cycle pop is dropped, and overflow is set.
- pop = (count_ref != 0) && (count_uut != 0). Both FIFOs pop together.
- At a pop, the two heads are compared with equality over all WIDTH bits.
- The result is registered: the next cycle has match_valid=1 and mismatch equal to the inequality result.
- On a mismatch result:
  - error is set.
  - err_count increments and saturates at 16'hFFFF.
- Simultaneous push and pop on one side leaves that side's count unchanged.
- clear=1:
  - error, overflow and err_count go to 0, as do first_ref/first_uut when capture is enabled.
  - A mismatch registered in the same cycle as clear is discarded from the flags and counter. Clear wins.
  - match_valid/mismatch are still presented.
- Reset values (asynchronous rst): all pointers and counts 0, and all outputs 0.
- Reset mid-stream discards all buffered samples.

## Timing
- Aligned inputs (both valid at cycle N, FIFOs empty):
  - Write at N.
  - Pop and compare at N+1.
  - match_valid at N+2.
- Skewed inputs: the result appears 2 cycles after the later of the two samples arrives.
- Throughput: one compare per cycle when both streams are continuous.
- Maximum absorbed skew: DEPTH samples.
- error, overflow and err_count update in the same cycle that match_valid/mismatch (or the drop) is registered.

## Configuration
- LOCKSTEP_FIRST_ERR_CAPTURE_EN.
- Defined:
  - On the first mismatch while error==0, first_ref/first_uut load the two compared heads.
  - They hold until clear or rst.
- Undefined:
  - first_ref/first_uut are driven constant 0.
  - No capture registers are built.
  - All other behaviour is identical.

## Structure
- Package lockstep_pkg holds:
  - localparam CNT_W=16.
  - typedef logic [CNT_W-1:0] err_cnt_t.
  - localparam err_cnt_t ERR_CNT_MAX='1.
- Sub-module skew_fifo (WIDTH, DEPTH) is instantiated twice, once per side.
  - Ports: push, din, pop, dout, count, full, drop.
- The top level contains the pop logic, the compare register, the sticky flags, the counter and the capture registers.

## Test plan
- Aligned streams 8'h11, 8'h22, 8'h33 on both sides: match_valid at cycles 2, 3, 4 with mismatch=0; error=0; err_count=0.
- UUT delayed 3 cycles, identical data: no mismatch, overflow=0, results begin 2 cycles after the first UUT sample.
- Ref 8'hA5 and UUT 8'hA4 at the 2nd pair: mismatch=1 on that result, error=1, err_count=1. With the macro defined, first_ref=8'hA5 and first_uut=8'hA4; a later mismatch 8'h00/8'hFF leaves the capture unchanged.
- DEPTH=4, ref sends 5 samples while uut is idle: 5th sample dropped, overflow=1, count_ref stays 4.
- Force err_count to 16'hFFFF via repeated mismatches, then one more mismatch: count stays 16'hFFFF. Pulse clear in the same cycle as a mismatch result: error=0, err_count=0.
- Assert rst with 2 samples buffered: all outputs 0 immediately. After release, fresh aligned data compares cleanly with no stale pairing.
